// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state type and opcode classification for alu_req_arbiter.
// The opcode check helper is only consulted when ALU_ARB_OPCHECK_EN is defined.
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_NOR  = 4'b0001;
    localparam logic [3:0] OP_GT   = 4'b0010;
    localparam logic [3:0] OP_SHL1 = 4'b0011;
    localparam logic [3:0] OP_EQ   = 4'b0100;
    localparam logic [3:0] OP_ADD  = 4'b1010;
    localparam logic [3:0] OP_SUB  = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } arb_state_t;

    // ADD/SUB go through the ALU's registered adder path and need one extra cycle.
    function automatic logic op_is_clocked(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    function automatic logic op_is_defined(input logic [3:0] op);
        case (op)
            OP_AND, OP_NOR, OP_GT, OP_SHL1, OP_EQ, OP_ADD, OP_SUB: return 1'b1;
            default:                                              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant: on a tie the requester that did not win last time is granted.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    assign gnt[0] = req[0] & (~req[1] | last);
    assign gnt[1] = req[1] & (~req[0] | ~last);

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one ALU between two requesters: round-robin grant, operand latch, per-opcode wait, registered response.
// Optional ALU_ARB_OPCHECK_EN: undefined opcodes bypass the ALU and respond with rsp_err=1.
//
// state   | meaning
// IDLE    | no operation in flight; grant one valid requester and latch its operands
// EXEC    | latched operands on the ALU pins; single-cycle ops captured here
// WAIT    | extra cycle for ADD/SUB; result captured at the end
// RESP    | owner's rspN_valid high, result held until rspN_ready
module alu_req_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,

    output logic              rsp0_valid,
    output logic              rsp1_valid,
    input  logic              rsp0_ready,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              rsp_err,

    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,

    output logic              busy
);

    arb_state_t        state;
    logic              last;
    logic              owner;
    logic [OP_W-1:0]   op_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] res_q;
    logic              zero_q;
    logic              rsp0_q;
    logic              rsp1_q;
    logic              busy_q;

    logic [1:0]        gnt;
    logic              accept;
    logic              rsp_hs;
    logic [OP_W-1:0]   sel_op;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;
    logic              sel_bad;

    rr_arb2 u_rr_arb2 (
        .req  ({req1_valid, req0_valid}),
        .last (last),
        .gnt  (gnt)
    );

    // Grant is only visible in IDLE; a request seen while reset is high is not taken.
    assign accept     = (state == ST_IDLE) && !reset && (gnt != 2'b00);
    assign req0_ready = accept & gnt[0];
    assign req1_ready = accept & gnt[1];

    assign sel_op = gnt[1] ? req1_op : req0_op;
    assign sel_a  = gnt[1] ? req1_a  : req0_a;
    assign sel_b  = gnt[1] ? req1_b  : req0_b;

    assign rsp_hs = (rsp0_q & rsp0_ready) | (rsp1_q & rsp1_ready);

`ifdef ALU_ARB_OPCHECK_EN
    logic err_q;

    assign sel_bad = !op_is_defined(sel_op);

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= sel_bad;
        end
    end

    assign rsp_err = err_q;
`else
    assign sel_bad = 1'b0;
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            last   <= 1'b1;
            owner  <= 1'b0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            zero_q <= 1'b0;
            rsp0_q <= 1'b0;
            rsp1_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        owner  <= gnt[1];
                        last   <= gnt[1];
                        op_q   <= sel_op;
                        a_q    <= sel_a;
                        b_q    <= sel_b;
                        busy_q <= 1'b1;
                        if (sel_bad) begin
                            // Rejected opcode never reaches the ALU; answer immediately.
                            state  <= ST_RESP;
                            res_q  <= '0;
                            zero_q <= 1'b1;
                            rsp0_q <= gnt[0];
                            rsp1_q <= gnt[1];
                        end else begin
                            state <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    if (op_is_clocked(op_q)) begin
                        state <= ST_WAIT;
                    end else begin
                        state  <= ST_RESP;
                        res_q  <= alu_result;
                        zero_q <= alu_zero;
                        rsp0_q <= ~owner;
                        rsp1_q <= owner;
                    end
                end
                ST_WAIT: begin
                    state  <= ST_RESP;
                    res_q  <= alu_result;
                    zero_q <= alu_zero;
                    rsp0_q <= ~owner;
                    rsp1_q <= owner;
                end
                ST_RESP: begin
                    if (rsp_hs) begin
                        state  <= ST_IDLE;
                        rsp0_q <= 1'b0;
                        rsp1_q <= 1'b0;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_op     = op_q;
    assign rsp_result = res_q;
    assign rsp_zero   = zero_q;
    assign rsp0_valid = rsp0_q;
    assign rsp1_valid = rsp1_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Self-checking bench for alu_req_arbiter with a behavioural ALU and a transaction-level reference model.
module tb_alu_req_arbiter;
    import alu_pkg::*;

    localparam int DATA_W = 64;
    localparam int OP_W   = 4;

    logic              clk;
    logic              reset;
    logic              req0_valid, req0_ready, req1_valid, req1_ready;
    logic [OP_W-1:0]   req0_op, req1_op;
    logic [DATA_W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic              rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_zero, rsp_err;
    logic [DATA_W-1:0] alu_a, alu_b, alu_result;
    logic [OP_W-1:0]   alu_op;
    logic              alu_zero;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic exp_last;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    alu_req_arbiter #(.DATA_W(DATA_W), .OP_W(OP_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp0_valid (rsp0_valid),
        .rsp1_valid (rsp1_valid),
        .rsp0_ready (rsp0_ready),
        .rsp1_ready (rsp1_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .busy       (busy)
    );

    // Behavioural ALU; undefined codes produce a recognisable scramble.
    function automatic logic [63:0] alu_fn(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        case (op)
            4'b0000: return a & b;
            4'b0001: return ~(a | b);
            4'b0010: return (a > b) ? 64'd1 : 64'd0;
            4'b0011: return a << 1;
            4'b0100: return (a == b) ? 64'd1 : 64'd0;
            4'b1010: return a + b;
            4'b1100: return a - b;
            default: return a ^ b ^ 64'h5A5A_0F0F_C3C3_9696;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_op, alu_a, alu_b);
    assign alu_zero   = (alu_result == 64'd0);

    function automatic bit ref_defined(input logic [3:0] op);
        return op inside {4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b1010, 4'b1100};
    endfunction

    function automatic bit ref_rejected(input logic [3:0] op);
`ifdef ALU_ARB_OPCHECK_EN
        return !ref_defined(op);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int ref_lat(input logic [3:0] op);
        if (ref_rejected(op)) return 1;
        if (op == 4'b1010 || op == 4'b1100) return 3;
        return 2;
    endfunction

    // Expected {result, zero, err} for an accepted operation.
    function automatic logic [65:0] ref_rsp(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] r;
        if (ref_rejected(op)) return {64'd0, 1'b1, 1'b1};
        r = alu_fn(op, a, b);
        return {r, (r == 64'd0), 1'b0};
    endfunction

    function automatic logic [3:0] rand_op();
        logic [3:0] ops [7];
        int idx;
        ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b1010, 4'b1100};
        idx = $urandom_range(0, 8);
        if (idx < 7) return ops[idx];
        return 4'($urandom_range(0, 15));
    endfunction

    function automatic logic [63:0] rand64();
        return {32'($urandom), 32'($urandom)};
    endfunction

    task automatic idle_inputs();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_last = 1'b1;
        #1;
    endtask

    // Drives one request set and reports what the DUT did; callers judge it against the model.
    task automatic run_txn(input logic [1:0] mask,
                           input logic [3:0] op0, input logic [63:0] a0, input logic [63:0] b0,
                           input logic [3:0] op1, input logic [63:0] a1, input logic [63:0] b1,
                           input int bp,
                           output int port, output int wt, output int lat,
                           output logic [63:0] res, output logic zero, output logic err,
                           output int viol);
        port = -1; wt = -1; lat = -1; res = '0; zero = 1'b0; err = 1'b0; viol = 0;
        req0_valid = mask[0]; req0_op = op0; req0_a = a0; req0_b = b0;
        req1_valid = mask[1]; req1_op = op1; req1_a = a1; req1_b = b1;
        rsp0_ready = (bp == 0);
        rsp1_ready = (bp == 0);
        #1;
        for (int k = 0; k < 20; k++) begin
            if (req0_ready && req1_ready) viol++;
            if (req0_ready) begin port = 0; wt = k; break; end
            if (req1_ready) begin port = 1; wt = k; break; end
            @(negedge clk); #1;
        end
        if (port < 0) return;
        @(negedge clk);
        if (port == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        #1;
        for (int k = 1; k <= 8; k++) begin
            if (req0_ready || req1_ready) viol++;
            if (!busy) viol++;
            if (port == 0 ? rsp1_valid : rsp0_valid) viol++;
            if (port == 0 ? rsp0_valid : rsp1_valid) begin lat = k; break; end
            @(negedge clk); #1;
        end
        if (lat < 0) return;
        res = rsp_result; zero = rsp_zero; err = rsp_err;
        for (int k = 0; k < bp; k++) begin
            @(negedge clk); #1;
            if (rsp_result !== res || rsp_zero !== zero || rsp_err !== err) viol++;
            if (!(port == 0 ? rsp0_valid : rsp1_valid)) viol++;
            if (req0_ready || req1_ready || !busy) viol++;
            if (k == bp - 1) begin rsp0_ready = 1'b1; rsp1_ready = 1'b1; end
        end
        @(negedge clk); #1;
        if (busy || rsp0_valid || rsp1_valid) viol++;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, rsp_err, rsp_zero} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 0000000",
                     {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, rsp_err, rsp_zero});
        end
        n_checks++;
        if (rsp_result !== 64'd0 || alu_a !== 64'd0 || alu_b !== 64'd0 || alu_op !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_data: result=%h a=%h b=%h op=%b expected all zero", rsp_result, alu_a, alu_b, alu_op);
        end
        reset = 1'b0;
        exp_last = 1'b1;
        @(negedge clk); #1;
        n_checks++;
        if (busy !== 1'b0 || rsp0_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: busy=%b rsp0_valid=%b expected 0 0", busy, rsp0_valid);
        end
    endtask

    task automatic test_single_add();
        int p, w, l, v; logic [63:0] r; logic z, e;
        run_txn(2'b01, OP_ADD, 64'd5, 64'd3, 4'd0, 64'd0, 64'd0, 0, p, w, l, r, z, e, v);
        exp_last = 1'b0;
        n_checks++;
        if ({p, w, l, v} !== {32'd0, 32'd0, 32'd3, 32'd0}) begin
            n_fail++;
            $display("FAIL add_timing: port=%0d wait=%0d lat=%0d viol=%0d expected 0 0 3 0", p, w, l, v);
        end
        n_checks++;
        if ({r, z, e} !== {64'd8, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL add_data: result=%0d zero=%b err=%b expected 8 0 0", r, z, e);
        end
    endtask

    task automatic test_tie();
        int p, w, l, v; logic [63:0] r; logic z, e;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            run_txn(2'b11, OP_AND, 64'hF0, 64'h0F, OP_EQ, 64'd7, 64'd7, 0, p, w, l, r, z, e, v);
            n_checks++;
            if ({p, w, l, v} !== {i, 32'd0, 32'd2, 32'd0}) begin
                n_fail++;
                $display("FAIL tie_timing_%0d: port=%0d wait=%0d lat=%0d viol=%0d expected %0d 0 2 0", i, p, w, l, v, i);
            end
            n_checks++;
            if ({r, z, e} !== ((i == 0) ? {64'd0, 1'b1, 1'b0} : {64'd1, 1'b0, 1'b0})) begin
                n_fail++;
                $display("FAIL tie_data_%0d: result=%0d zero=%b err=%b", i, r, z, e);
            end
        end
        exp_last = 1'b1;
        idle_inputs();
    endtask

    task automatic test_backpressure();
        int p, w, l, v; logic [63:0] r; logic z, e;
        exp_last = 1'b0;
        run_txn(2'b01, OP_SUB, 64'd9, 64'd9, 4'd0, 64'd0, 64'd0, 5, p, w, l, r, z, e, v);
        n_checks++;
        if ({p, l, v} !== {32'd0, 32'd3, 32'd0}) begin
            n_fail++;
            $display("FAIL bp_timing: port=%0d lat=%0d viol=%0d expected 0 3 0", p, l, v);
        end
        n_checks++;
        if ({r, z, e} !== {64'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL bp_data: result=%0d zero=%b err=%b expected 0 1 0", r, z, e);
        end
    endtask

    task automatic test_reset_midflight();
        int p, w, l, v; logic [63:0] r; logic z, e;
        logic [63:0] a, b;
        @(negedge clk);
        req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 64'd11; req0_b = 64'd22;
        #1;
        n_checks++;
        if (req0_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_accept: req0_ready=%b expected 1", req0_ready);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk); #1;
        n_checks++;
        if ({rsp0_valid, rsp1_valid, busy, rsp_zero, rsp_err, rsp_result, alu_a, alu_b, alu_op} !== '0) begin
            n_fail++;
            $display("FAIL midrst_state: rsp=%b%b busy=%b result=%h a=%h b=%h op=%b expected all zero",
                     rsp0_valid, rsp1_valid, busy, rsp_result, alu_a, alu_b, alu_op);
        end
        reset = 1'b0;
        exp_last = 1'b1;
        v = 0;
        repeat (4) begin
            @(negedge clk); #1;
            if (rsp0_valid || rsp1_valid || busy) v++;
        end
        n_checks++;
        if (v !== 0) begin
            n_fail++;
            $display("FAIL midrst_quiet: %0d cycles with activity expected 0", v);
        end
        a = rand64(); b = rand64();
        run_txn(2'b01, OP_NOR, a, b, 4'd0, 64'd0, 64'd0, 0, p, w, l, r, z, e, v);
        exp_last = 1'b0;
        n_checks++;
        if ({p, w, l, v, r, z, e} !== {32'd0, 32'd0, 32'd2, 32'd0, ref_rsp(OP_NOR, a, b)}) begin
            n_fail++;
            $display("FAIL midrst_after: port=%0d wait=%0d lat=%0d viol=%0d result=%h expected 0 0 2 0 %h",
                     p, w, l, v, r, ~(a | b));
        end
    endtask

    task automatic test_undefined_op();
        int p, w, l, v; logic [63:0] r; logic z, e;
        logic [63:0] a, b;
        logic [65:0] exp;
        a = rand64(); b = rand64();
        exp = ref_rsp(4'b1111, a, b);
        run_txn(2'b01, 4'b1111, a, b, 4'd0, 64'd0, 64'd0, 0, p, w, l, r, z, e, v);
        exp_last = 1'b0;
        n_checks++;
        if ({p, w, l, v} !== {32'd0, 32'd0, ref_lat(4'b1111), 32'd0}) begin
            n_fail++;
            $display("FAIL undef_timing: port=%0d wait=%0d lat=%0d viol=%0d expected 0 0 %0d 0", p, w, l, v, ref_lat(4'b1111));
        end
        n_checks++;
        if ({r, z, e} !== exp) begin
            n_fail++;
            $display("FAIL undef_data: result=%h zero=%b err=%b expected %h %b %b", r, z, e, exp[65:2], exp[1], exp[0]);
        end
    endtask

    task automatic test_back_to_back();
        int p, w, l, v; logic [63:0] r; logic z, e;
        logic [3:0] o0, o1; logic [63:0] a0, b0, a1, b1;
        logic [65:0] exp;
        int winner;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            o0 = (i % 2 == 0) ? OP_ADD : OP_GT;
            o1 = (i % 2 == 0) ? OP_SHL1 : OP_SUB;
            a0 = rand64(); b0 = rand64(); a1 = rand64(); b1 = rand64();
            winner = exp_last ? 0 : 1;
            exp = (winner == 0) ? ref_rsp(o0, a0, b0) : ref_rsp(o1, a1, b1);
            run_txn(2'b11, o0, a0, b0, o1, a1, b1, 0, p, w, l, r, z, e, v);
            n_checks++;
            if ({p, w, l, v} !== {winner, 32'd0, ref_lat(winner == 0 ? o0 : o1), 32'd0}) begin
                n_fail++;
                $display("FAIL b2b_timing_%0d: port=%0d wait=%0d lat=%0d viol=%0d expected %0d 0 %0d 0",
                         i, p, w, l, v, winner, ref_lat(winner == 0 ? o0 : o1));
            end
            n_checks++;
            if ({r, z, e} !== exp) begin
                n_fail++;
                $display("FAIL b2b_data_%0d: result=%h zero=%b err=%b expected %h %b %b", i, r, z, e, exp[65:2], exp[1], exp[0]);
            end
            exp_last = (winner == 1);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        int p, w, l, v; logic [63:0] r; logic z, e;
        logic [3:0] o0, o1; logic [63:0] a0, b0, a1, b1;
        logic [1:0] mask;
        logic [65:0] exp;
        int winner, bp;
        for (int i = 0; i < 40; i++) begin
            mask = 2'($urandom_range(1, 3));
            o0 = rand_op(); o1 = rand_op();
            a0 = rand64(); b0 = ($urandom_range(0, 3) == 0) ? a0 : rand64();
            a1 = rand64(); b1 = ($urandom_range(0, 3) == 0) ? a1 : rand64();
            bp = $urandom_range(0, 2);
            winner = (mask == 2'b11) ? (exp_last ? 0 : 1) : (mask[0] ? 0 : 1);
            exp = (winner == 0) ? ref_rsp(o0, a0, b0) : ref_rsp(o1, a1, b1);
            run_txn(mask, o0, a0, b0, o1, a1, b1, bp, p, w, l, r, z, e, v);
            n_checks++;
            if ({p, w, l, v} !== {winner, 32'd0, ref_lat(winner == 0 ? o0 : o1), 32'd0}) begin
                n_fail++;
                $display("FAIL rand_timing_%0d: port=%0d wait=%0d lat=%0d viol=%0d expected %0d 0 %0d 0",
                         i, p, w, l, v, winner, ref_lat(winner == 0 ? o0 : o1));
            end
            n_checks++;
            if ({r, z, e} !== exp) begin
                n_fail++;
                $display("FAIL rand_data_%0d: result=%h zero=%b err=%b expected %h %b %b", i, r, z, e, exp[65:2], exp[1], exp[0]);
            end
            exp_last = (winner == 1);
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        req0_op = '0; req0_a = '0; req0_b = '0;
        req1_op = '0; req1_a = '0; req1_b = '0;
        idle_inputs();
        test_reset();
        test_single_add();
        test_tie();
        test_backpressure();
        test_reset_midflight();
        test_undefined_op();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
